// File: rtl/uart_dbg_loader_pkg.sv
// Shared definitions for the UART debug loader: command/ack bytes and FSM state encoding.
package uart_dbg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_dbg_loader_if.sv
// Debug memory port driven by the loader towards the debug-port mux.
interface uart_dbg_loader_if;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;

    modport master (output dbg_mem_op, output dbg_wren, output dbg_adr, output dbg_do);
    modport slave  (input  dbg_mem_op, input  dbg_wren, input  dbg_adr, input  dbg_do);
endinterface

// File: rtl/uart_dbg_loader_word_asm.sv
// Little-endian byte-to-word assembler; done_o pulses with the 4th byte while word_o is complete.
module dbg_word_asm (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);
    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    // The incoming byte is merged combinationally so the word is usable on the done cycle.
    assign word_o = {byte_i, shift_q};
    assign done_o = push_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (clr_i) begin
            cnt_q   <= 2'd0;
        end else if (push_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end
endmodule

// File: rtl/uart_dbg_loader.sv
// UART byte-stream parser driving the debug memory port and the CPU reset.
// Optional ack/nak back-channel enabled by defining UART_DBG_ACK_EN.
//   state | meaning
//   IDLE  | waiting for H / G / W command byte
//   ADDR  | collecting 4 address bytes, inter-byte timeout armed
//   DATA  | collecting 4 data bytes, inter-byte timeout armed
//   WRITE | holding the write strobe, or refusing it if the core runs
//   ACK   | presenting ack/nak byte until tx_ready
module uart_dbg_loader
    import uart_dbg_loader_pkg::*;
#(
    parameter int unsigned WR_HOLD     = 4,
    parameter int unsigned TIMEOUT     = 100000,
    parameter bit          BOOT_HALTED = 1'b1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    uart_dbg_loader_if.master  dbg,
    output logic               cpu_n_reset,
    output logic               busy,
    output logic               err
`ifdef UART_DBG_ACK_EN
    ,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
`endif
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_INIT  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    HOLD_INIT = 8'(WR_HOLD - 1);

    state_e        state_q, state_d;
    logic          cpu_n_reset_q, cpu_n_reset_d;
    logic          err_q, err_d;
    logic          busy_q;
    logic          mem_op_q, mem_op_d;
    logic [3:0]    wren_q, wren_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   do_q, do_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    hold_q, hold_d;
    logic [TW-1:0] tmo_q, tmo_d;
`ifdef UART_DBG_ACK_EN
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
`endif

    logic        in_payload, tmo_expire, asm_push, asm_clr, asm_done;
    logic [31:0] asm_word;

    // An expiring timeout takes priority over a byte arriving on the same cycle.
    assign in_payload = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign tmo_expire = in_payload && (tmo_q == '0);
    assign asm_push   = rx_valid && in_payload && !tmo_expire;
    assign asm_clr    = (state_q == ST_IDLE) || tmo_expire;

    dbg_word_asm u_asm (
        .clk     (clk),
        .n_reset (n_reset),
        .clr_i   (asm_clr),
        .push_i  (asm_push),
        .byte_i  (rx_data),
        .word_o  (asm_word),
        .done_o  (asm_done)
    );

    always_comb begin
        state_d       = state_q;
        cpu_n_reset_d = cpu_n_reset_q;
        err_d         = err_q;
        mem_op_d      = mem_op_q;
        wren_d        = wren_q;
        adr_d         = adr_q;
        do_d          = do_q;
        addr_d        = addr_q;
        hold_d        = hold_q;
        tmo_d         = tmo_q;
`ifdef UART_DBG_ACK_EN
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_HALT: begin
                            cpu_n_reset_d = 1'b0;
                            err_d         = 1'b0;
`ifdef UART_DBG_ACK_EN
                            state_d       = ST_ACK;
                            tx_valid_d    = 1'b1;
                            tx_data_d     = ACK_BYTE;
`endif
                        end
                        CMD_GO: begin
                            cpu_n_reset_d = 1'b1;
`ifdef UART_DBG_ACK_EN
                            state_d       = ST_ACK;
                            tx_valid_d    = 1'b1;
                            tx_data_d     = ACK_BYTE;
`endif
                        end
                        CMD_WRITE: begin
                            state_d = ST_ADDR;
                            tmo_d   = TMO_INIT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ADDR, ST_DATA: begin
                if (tmo_expire) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    tmo_d = TMO_INIT;
                    if (asm_done) begin
                        if (state_q == ST_ADDR) begin
                            addr_d  = asm_word;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_WRITE;
                            hold_d  = 8'd0;
                            if (!cpu_n_reset_q) begin
                                mem_op_d = 1'b1;
                                wren_d   = 4'hF;
                                adr_d    = addr_q;
                                do_d     = asm_word;
                                hold_d   = HOLD_INIT;
                            end
                        end
                    end
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_WRITE: begin
                if (rx_valid || cpu_n_reset_q) err_d = 1'b1;
                if (hold_q == 8'd0) begin
                    mem_op_d = 1'b0;
                    wren_d   = 4'h0;
`ifdef UART_DBG_ACK_EN
                    state_d    = ST_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = cpu_n_reset_q ? NAK_BYTE : ACK_BYTE;
`else
                    state_d  = ST_IDLE;
`endif
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
`ifdef UART_DBG_ACK_EN
            ST_ACK: begin
                if (rx_valid) err_d = 1'b1;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            cpu_n_reset_q <= !BOOT_HALTED;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            mem_op_q      <= 1'b0;
            wren_q        <= 4'h0;
            adr_q         <= 32'd0;
            do_q          <= 32'd0;
            addr_q        <= 32'd0;
            hold_q        <= 8'd0;
            tmo_q         <= '0;
`ifdef UART_DBG_ACK_EN
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            err_q         <= err_d;
            busy_q        <= (state_d != ST_IDLE);
            mem_op_q      <= mem_op_d;
            wren_q        <= wren_d;
            adr_q         <= adr_d;
            do_q          <= do_d;
            addr_q        <= addr_d;
            hold_q        <= hold_d;
            tmo_q         <= tmo_d;
`ifdef UART_DBG_ACK_EN
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
`endif
        end
    end

    assign cpu_n_reset    = cpu_n_reset_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign dbg.dbg_mem_op = mem_op_q;
    assign dbg.dbg_wren   = wren_q;
    assign dbg.dbg_adr    = adr_q;
    assign dbg.dbg_do     = do_q;
`ifdef UART_DBG_ACK_EN
    assign tx_valid       = tx_valid_q;
    assign tx_data        = tx_data_q;
`endif
endmodule

// File: tb/tb_uart_dbg_loader.sv
// Randomized bench for uart_dbg_loader against a command-level model of halt/err/write behaviour.
module tb_uart_dbg_loader;
    localparam int WR_HOLD = 8;
    localparam int TIMEOUT = 200;
    localparam logic [7:0] B_H = 8'h48, B_G = 8'h47, B_W = 8'h57;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cpu_n_reset, busy, err;
`ifdef UART_DBG_ACK_EN
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
`endif

    uart_dbg_loader_if dbg_if ();

    uart_dbg_loader #(.WR_HOLD(WR_HOLD), .TIMEOUT(TIMEOUT), .BOOT_HALTED(1'b1)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .dbg         (dbg_if),
        .cpu_n_reset (cpu_n_reset),
        .busy        (busy),
        .err         (err)
`ifdef UART_DBG_ACK_EN
        ,
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Write-pulse monitor: length, captured address/data, and stability during the pulse.
    int          pulses = 0, last_len = 0, cur_len = 0, stab_err = 0;
    logic [31:0] cap_adr = 0, cap_do = 0;
    logic        prev_op = 1'b0;

    always @(negedge clk) begin
        if (dbg_if.dbg_mem_op === 1'b1) begin
            if (!prev_op) begin
                cur_len = 0;
                cap_adr = dbg_if.dbg_adr;
                cap_do  = dbg_if.dbg_do;
            end else if (dbg_if.dbg_adr !== cap_adr || dbg_if.dbg_do !== cap_do) begin
                stab_err++;
            end
            if (dbg_if.dbg_wren !== 4'hF) stab_err++;
            cur_len++;
        end else if (prev_op) begin
            last_len = cur_len;
            pulses++;
        end
        prev_op = (dbg_if.dbg_mem_op === 1'b1);
    end

    // Reference model state
    bit          m_halted = 1'b1;
    bit          m_err    = 1'b0;
    logic [31:0] m_adr    = 32'd0;
    logic [31:0] m_do     = 32'd0;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap();
        idle($urandom_range(0, 3));
    endtask

    task automatic command(input logic [7:0] c);
        send_byte(c);
        idle(4);
        if (c == B_H) begin
            m_halted = 1'b1;
            m_err    = 1'b0;
        end else if (c == B_G) begin
            m_halted = 1'b0;
        end
        chk("cmd_cpu_n_reset", {31'd0, cpu_n_reset}, {31'd0, !m_halted});
        chk("cmd_err", {31'd0, err}, {31'd0, m_err});
        chk("cmd_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic send_frame_bytes(input logic [31:0] a, input logic [31:0] d);
        send_byte(B_W);
        gap();
        for (int i = 0; i < 4; i++) begin
            send_byte(a[8*i +: 8]);
            gap();
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(d[8*i +: 8]);
            if (i < 3) gap();
        end
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] d, input bit inject);
        int p0;
        p0 = pulses;
        send_frame_bytes(a, d);
        if (inject) begin
            idle(2);
            send_byte(B_W);
            m_err = 1'b1;
        end
        idle(WR_HOLD + 4);
        if (m_halted) begin
            m_adr = a;
            m_do  = d;
            chk("wr_pulses", pulses, p0 + 1);
            chk("wr_len", last_len, WR_HOLD);
            chk("wr_cap_adr", cap_adr, a);
            chk("wr_cap_do", cap_do, d);
        end else begin
            m_err = 1'b1;
            chk("refused_pulses", pulses, p0);
        end
        chk("hold_adr", dbg_if.dbg_adr, m_adr);
        chk("hold_do", dbg_if.dbg_do, m_do);
        chk("post_wren", {28'd0, dbg_if.dbg_wren}, 32'd0);
        chk("post_err", {31'd0, err}, {31'd0, m_err});
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("stability", stab_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] j;
        idle(3);
        chk("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        chk("rst_mem_op", {31'd0, dbg_if.dbg_mem_op}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wren", {28'd0, dbg_if.dbg_wren}, 32'd0);
        chk("rst_adr", dbg_if.dbg_adr, 32'd0);
        chk("rst_do", dbg_if.dbg_do, 32'd0);
`ifdef UART_DBG_ACK_EN
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
`endif
        n_reset = 1'b1;
        idle(2);

        frame(32'h0002_0000, 32'h0000_0537, 1'b0);

        command(B_G);
        frame(32'h0000_0000, 32'h0000_00AA, 1'b0);
        command(B_H);

        // Abandoned address phase must time out and leave no write behind.
        p0 = pulses;
        send_byte(B_W);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h02);
        idle(TIMEOUT - 10);
        chk("tmo_busy_before", {31'd0, busy}, 32'd1);
        idle(15);
        chk("tmo_busy_after", {31'd0, busy}, 32'd0);
        chk("tmo_no_write", pulses, p0);
        chk("tmo_err", {31'd0, err}, {31'd0, m_err});
        frame(32'h0002_0020, 32'hDEAD_BEEF, 1'b0);

        frame($urandom, $urandom, 1'b1);
        command(B_H);

`ifdef UART_DBG_ACK_EN
        tx_ready = 1'b0;
        send_frame_bytes(32'h0000_1000, 32'h1234_5678);
        m_adr = 32'h0000_1000;
        m_do  = 32'h1234_5678;
        idle(WR_HOLD + 10);
        chk("ack_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("ack_tx_data", {24'd0, tx_data}, 32'h06);
        chk("ack_busy", {31'd0, busy}, 32'd1);
        tx_ready = 1'b1;
        idle(2);
        chk("ack_tx_valid_done", {31'd0, tx_valid}, 32'd0);
        chk("ack_busy_done", {31'd0, busy}, 32'd0);
        chk("ack_adr", dbg_if.dbg_adr, m_adr);
`endif

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 9))
                0, 1: command(B_H);
                2:    command(B_G);
                3: begin
                    j = 8'($urandom);
                    while (j == B_H || j == B_G || j == B_W) j = 8'($urandom);
                    command(j);
                end
                default: frame($urandom, $urandom, 1'b0);
            endcase
        end

        // Asynchronous reset in the middle of a write pulse.
        command(B_H);
        send_frame_bytes(32'hCAFE_0004, 32'h0BAD_F00D);
        idle(3);
        chk("midwr_mem_op_high", {31'd0, dbg_if.dbg_mem_op}, 32'd1);
        n_reset = 1'b0;
        #1;
        chk("midwr_mem_op_drop", {31'd0, dbg_if.dbg_mem_op}, 32'd0);
        chk("midwr_busy", {31'd0, busy}, 32'd0);
        chk("midwr_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
